mem_access_unit: RTL and testbench

- Load/store sequencer placed directly upstream of the word-addressed data memory.
- Turns core byte/halfword/word load and store requests into memory read/write cycles.
- Sub-word stores use read-modify-write (read the word, merge the bytes, write it back).
- Loads return sign- or zero-extended data; alignment and range errors are flagged and no memory access is issued for them.

---
 rtl/mem_access_pkg.sv | 50 +++++
 rtl/mem_access_unit_mem_lane_mux.sv | 53 +++++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Purpose : shared op codes, FSM states, status codes and helpers for the load/store sequencer.
// Latency : n/a (types and pure functions only).
// Backpres: n/a.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_ALIGN = 2'b01,
        ERR_RANGE = 2'b10
    } err_e;

    function automatic logic is_load(input op_e op);
        is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                  (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_subword(input op_e op);
        is_subword = (op == OP_SB) || (op == OP_SH);
    endfunction

    // Anything not recognised as a legal access is reported as misaligned,
    // so it completes without touching memory.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU, OP_SB: is_misaligned = 1'b0;
            OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
            OP_LW, OP_SW:         is_misaligned = (lo != 2'b00);
            default:              is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_mem_lane_mux.sv
// Purpose : byte/half lane select + sign/zero extension for loads, lane merge for stores.
// Latency : combinational.
// Backpres: none (pure datapath).
// Ports   : op/byte_off select the lane; ld_word -> ld_dat (extended load result);
//           st_word (old memory word) merged with st_data -> st_dat (word to write).
module mem_lane_mux
    import mem_access_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_dat,
    output logic [31:0] st_dat
);

    logic [4:0]  lane_lsb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Little-endian: byte k occupies bits [8k+7:8k].
    assign lane_lsb = {byte_off, 3'b000};

    always_comb begin
        ld_byte = ld_word[lane_lsb +: 8];
        ld_half = byte_off[1] ? ld_word[31:16] : ld_word[15:0];

        ld_dat = ld_word;
        case (op)
            OP_LB:   ld_dat = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_dat = {24'h000000, ld_byte};
            OP_LH:   ld_dat = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_dat = {16'h0000, ld_half};
            default: ld_dat = ld_word;
        endcase

        st_dat = st_word;
        case (op)
            OP_SB: st_dat[lane_lsb +: 8] = st_data[7:0];
            OP_SH: begin
                if (byte_off[1]) begin
                    st_dat[31:16] = st_data[15:0];
                end else begin
                    st_dat[15:0] = st_data[15:0];
                end
            end
            OP_SW:   st_dat = st_data;
            default: st_dat = st_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose : load/store sequencer in front of word-addressed data memory (RMW for sub-word stores).
// Latency : accept->done 2 cycles (loads, SW), 3 (SB/SH), 1 (errors).
// Backpres: single outstanding request; start is ignored while busy, no queueing.
// Ports   : start/op/addr/wdata request in; busy/done/err/rdata status out;
//           mem_read/mem_write/mem_addr/mem_wdata/mem_rdata to the data memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 2048,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [31:0]       rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_LIM = ADDR_W'(MEM_WORDS);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    err_e              err_q;

    op_e               op_in;
    err_e              acc_err;
    logic              accept;
    logic [31:0]       ld_dat;
    logic [31:0]       st_dat;

    assign op_in  = op_e'(op);
    assign accept = (state_q == ST_IDLE) && start;

    // Alignment is checked before range so a misaligned out-of-range address reports 01.
    always_comb begin
        acc_err = ERR_OK;
        if (is_misaligned(op_in, addr[1:0])) begin
            acc_err = ERR_ALIGN;
        end else if ((addr >> 2) >= WORD_LIM) begin
            acc_err = ERR_RANGE;
        end
    end

    mem_lane_mux u_lane_mux (
        .op       (op_q),
        .byte_off (addr_q[1:0]),
        .ld_word  (mem_rdata),
        .st_word  (word_q),
        .st_data  (wdata_q),
        .ld_dat   (ld_dat),
        .st_dat   (st_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory strobes decode from state only, so reset drops mem_write
    // asynchronously and an interrupted WRITE never reaches its commit edge.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (acc_err != ERR_OK) begin
                        state_d = ST_RESP;
                    end else if (is_load(op_in) || is_subword(op_in)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                mem_read = 1'b1;
                state_d  = is_load(op_q) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= acc_err;
            end
            if (state_q == ST_READ) begin
                word_q <= mem_rdata;
                // Load result lands as RESP is entered; stores keep the old rdata.
                if (is_load(op_q)) begin
                    rdata_q <= ld_dat;
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = 32'({addr_q[ADDR_W-1:2], 2'b00});
    assign mem_wdata = (state_q == ST_WRITE) ? st_dat : 32'h0000_0000;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int MEM_WORDS = 2048;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] SB  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SW  = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] ref_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, commit on the falling edge of a write cycle.
    assign mem_rdata = mem_read ? mem[mem_addr[12:2]] : 32'hDEAD_BEEF;
    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[12:2]] <= mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: access size/alignment/range rules and little-endian lanes in plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [1:0] e, output int nrd, output int nwr);
        int          size;
        bit          ld;
        bit          sgn;
        int unsigned w;
        int unsigned off;
        longint      val;
        longint      mask;
        ld   = (o == LB) || (o == LH) || (o == LW) || (o == LBU) || (o == LHU);
        sgn  = (o == LB) || (o == LH);
        size = (o == LB || o == LBU || o == SB) ? 1 : (o == LH || o == LHU || o == SH) ? 2 : 4;
        w    = a / 4;
        off  = a % 4;
        e = 2'b00; lat = 0; nrd = 0; nwr = 0;
        if ((a % size) != 0) begin
            e = 2'b01; lat = 1;
        end else if (w >= MEM_WORDS) begin
            e = 2'b10; lat = 1;
        end else if (ld) begin
            val = (longint'(ref_mem[w]) >> (8 * off)) % (64'sd1 << (8 * size));
            if (sgn && val >= (64'sd1 << (8 * size - 1))) val = val - (64'sd1 << (8 * size));
            ref_rdata = val[31:0];
            lat = 2; nrd = 1;
        end else if (size == 4) begin
            ref_mem[w] = d;
            lat = 2; nwr = 1;
        end else begin
            mask = ((64'sd1 << (8 * size)) - 1) << (8 * off);
            val  = (longint'(ref_mem[w]) & ~mask) | ((longint'(d) << (8 * off)) & mask);
            ref_mem[w] = val[31:0];
            lat = 3; nrd = 1; nwr = 1;
        end
    endtask

    task automatic run_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                           input bit hold, output int lat, output logic [1:0] e,
                           output logic [31:0] rd, output int nrd, output int nwr,
                           output logic busy_after);
        lat = 0; e = 2'b11; rd = 32'h0; nrd = 0; nwr = 0;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (!hold) begin
            // Scramble live inputs: the request must run from its registered copy.
            start = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
        end
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (done) begin
                lat = c; e = err; rd = rdata; start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        busy_after = busy;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;
        int          lat;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        bit          chk_word;
        logic [31:0] word_addr;
        logic [31:0] word;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                                input bit h, input int lat, input logic [1:0] e,
                                input logic [31:0] rd, input int nrd, input int nwr,
                                input bit cw, input logic [31:0] wa, input logic [31:0] w);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = d; v.hold = h; v.lat = lat; v.err = e;
        v.rdata = rd; v.nrd = nrd; v.nwr = nwr; v.chk_word = cw; v.word_addr = wa; v.word = w;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        int          lat, nrd, nwr, elat, enrd, enwr, done_seen, r;
        logic [1:0]  e, eerr;
        logic [31:0] rd, a, d;
        logic [2:0]  o;
        logic        bafter;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
        ref_rdata = 32'h0;

        //          op   addr        wdata        hold lat err    rdata        rd wr chk waddr        word
        vecs[0]  = mk(LB,  32'h11,   32'h0,        0, 2, 2'b00, 32'hFFFFFFAA, 1, 0, 1, 32'h10,   32'h8899AABB);
        vecs[1]  = mk(LBU, 32'h11,   32'h0,        0, 2, 2'b00, 32'h000000AA, 1, 0, 1, 32'h10,   32'h8899AABB);
        vecs[2]  = mk(LB,  32'h13,   32'h0,        0, 2, 2'b00, 32'hFFFFFF88, 1, 0, 0, 32'h0,    32'h0);
        vecs[3]  = mk(LH,  32'h12,   32'h0,        0, 2, 2'b00, 32'hFFFF8899, 1, 0, 0, 32'h0,    32'h0);
        vecs[4]  = mk(LW,  32'h10,   32'h0,        0, 2, 2'b00, 32'h8899AABB, 1, 0, 0, 32'h0,    32'h0);
        vecs[5]  = mk(SW,  32'h20,   32'h12345678, 0, 2, 2'b00, 32'h8899AABB, 0, 1, 1, 32'h20,   32'h12345678);
        vecs[6]  = mk(SB,  32'h22,   32'h000000EE, 1, 3, 2'b00, 32'h8899AABB, 1, 1, 1, 32'h20,   32'h12EE5678);
        vecs[7]  = mk(SH,  32'h30,   32'h0000BEEF, 0, 3, 2'b00, 32'h8899AABB, 1, 1, 1, 32'h30,   32'h0000BEEF);
        vecs[8]  = mk(LH,  32'h30,   32'h0,        0, 2, 2'b00, 32'hFFFFBEEF, 1, 0, 0, 32'h0,    32'h0);
        vecs[9]  = mk(LHU, 32'h30,   32'h0,        0, 2, 2'b00, 32'h0000BEEF, 1, 0, 0, 32'h0,    32'h0);
        vecs[10] = mk(SH,  32'h32,   32'hFFFF1234, 0, 3, 2'b00, 32'h0000BEEF, 1, 1, 1, 32'h30,   32'h1234BEEF);
        vecs[11] = mk(LW,  32'h06,   32'h0,        0, 1, 2'b01, 32'h0000BEEF, 0, 0, 1, 32'h04,   32'h0);
        vecs[12] = mk(LW,  32'h2000, 32'h0,        0, 1, 2'b10, 32'h0000BEEF, 0, 0, 0, 32'h0,    32'h0);
        vecs[13] = mk(SW,  32'h2002, 32'hFFFFFFFF, 0, 1, 2'b01, 32'h0000BEEF, 0, 0, 0, 32'h0,    32'h0);
        vecs[14] = mk(SH,  32'h33,   32'h00005555, 0, 1, 2'b01, 32'h0000BEEF, 0, 0, 1, 32'h30,   32'h1234BEEF);
        vecs[15] = mk(SW,  32'h1FFC, 32'hCAFEF00D, 0, 2, 2'b00, 32'h0000BEEF, 0, 1, 1, 32'h1FFC, 32'hCAFEF00D);
        vecs[16] = mk(LB,  32'h1FFF, 32'h0,        0, 2, 2'b00, 32'hFFFFFFCA, 1, 0, 0, 32'h0,    32'h0);
        vecs[17] = mk(SB,  32'h1FFD, 32'h00000012, 0, 3, 2'b00, 32'hFFFFFFCA, 1, 1, 1, 32'h1FFC, 32'hCAFE120D);
        vecs[18] = mk(LBU, 32'h2000, 32'h0,        0, 1, 2'b10, 32'hFFFFFFCA, 0, 0, 0, 32'h0,    32'h0);

        start = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0; rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_done",      32'(done),      32'h0);
        check("rst_err",       32'(err),       32'h0);
        check("rst_rdata",     rdata,          32'h0);
        check("rst_mem_read",  32'(mem_read),  32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_addr",  mem_addr,       32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, elat, eerr, enrd, enwr);
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold, lat, e, rd, nrd, nwr, bafter);
            check($sformatf("v%0d_lat", i),   32'(lat),    32'(vecs[i].lat));
            check($sformatf("v%0d_err", i),   32'(e),      32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), rd,          vecs[i].rdata);
            check($sformatf("v%0d_nrd", i),   32'(nrd),    32'(vecs[i].nrd));
            check($sformatf("v%0d_nwr", i),   32'(nwr),    32'(vecs[i].nwr));
            check($sformatf("v%0d_idle", i),  32'(bafter), 32'h0);
            if (vecs[i].chk_word)
                check($sformatf("v%0d_word", i), mem[vecs[i].word_addr[12:2]], vecs[i].word);
        end

        // Reset during the READ cycle of an SH: immediate reset values, no write, no done.
        mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        @(negedge clk);
        start = 1'b1; op = SH; addr = 32'h40; wdata = 32'h0000AAAA;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("sh_rst_in_read", 32'(mem_read), 32'h1);
        rst = 1'b1;
        #1;
        check("sh_rst_busy",      32'(busy),      32'h0);
        check("sh_rst_done",      32'(done),      32'h0);
        check("sh_rst_err",       32'(err),       32'h0);
        check("sh_rst_rdata",     rdata,          32'h0);
        check("sh_rst_mem_read",  32'(mem_read),  32'h0);
        check("sh_rst_mem_write", 32'(mem_write), 32'h0);
        check("sh_rst_mem_addr",  mem_addr,       32'h0);
        check("sh_rst_mem_wdata", mem_wdata,      32'h0);
        ref_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_write) done_seen++;
        end
        check("sh_rst_no_done", 32'(done_seen), 32'h0);
        check("sh_rst_word",    mem[16],        32'h11223344);

        // Reset inside a WRITE cycle, before its falling edge: the write is lost.
        mem[17] = 32'h55667788; ref_mem[17] = 32'h55667788;
        @(negedge clk);
        start = 1'b1; op = SW; addr = 32'h44; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("sw_rst_in_write", 32'(mem_write), 32'h1);
        rst = 1'b1;
        #1;
        check("sw_rst_mem_write", 32'(mem_write), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("sw_rst_no_done", 32'(done_seen), 32'h0);
        check("sw_rst_word",    mem[17],        32'h55667788);

        // Randomized requests against the reference model.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            o = 3'($urandom_range(0, 7));
            if (r < 8)       a = 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'h1FF0 + 32'($urandom_range(0, 15));
            else             a = 32'h2000 + 32'($urandom_range(0, 32'h7FFF0000));
            d = $urandom;
            model(o, a, d, elat, eerr, enrd, enwr);
            run_req(o, a, d, (i % 7) == 0, lat, e, rd, nrd, nwr, bafter);
            check($sformatf("r%0d_lat", i),   32'(lat),    32'(elat));
            check($sformatf("r%0d_err", i),   32'(e),      32'(eerr));
            check($sformatf("r%0d_rdata", i), rd,          ref_rdata);
            check($sformatf("r%0d_nrd", i),   32'(nrd),    32'(enrd));
            check($sformatf("r%0d_nwr", i),   32'(nwr),    32'(enwr));
            check($sformatf("r%0d_idle", i),  32'(bafter), 32'h0);
            if ((a >> 2) < MEM_WORDS)
                check($sformatf("r%0d_word", i), mem[a[12:2]], ref_mem[a[12:2]]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
